spi_xfer_seq: RTL and testbench

//  Sequences byte transfers on one SB_SPI hard core by driving the 8-bit host port of the

---
 rtl/spi_xfer_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: drives the 8-bit host port of an SB_SPI wishbone wrapper to configure the core
// and then stream bytes (valid/ready in, one-cycle rx_valid pulse out) without a CPU.
// Optional feature macro: SPI_SEQ_TIMEOUT_EN adds a bounded status-poll counter, the sticky
// err_timeout flag and drop-until-tx_last recovery. Without it the sequencer polls forever.
`timescale 1ns / 1ps

module spi_xfer_seq #(
    parameter logic [3:0] BASE    = 4'b0000,
    parameter logic [7:0] BR_VAL  = 8'h05,
    parameter logic [7:0] CR2_VAL = 8'hC0,
    parameter logic [7:0] CR1_VAL = 8'h80
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter logic [15:0] POLL_MAX = 16'd1023
`endif
) (
    input  logic       clk,
    input  logic       rst,
    output logic       bus_cs,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_din,
    input  logic [7:0] bus_dout,
    input  logic       bus_rdy,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       init_done,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [3:0] {
        StCfgBr,
        StCfgCr2,
        StCfgCr1,
        StIdle,
        StCsOn,
        StPollTrdy,
        StWrTx,
        StPollRrdy,
        StRdRx,
        StNext,
        StCsOff
    } state_e;

    // SB_SPI register offsets within the core's 16-register window
    localparam logic [3:0] RegCr1 = 4'h9;
    localparam logic [3:0] RegCr2 = 4'hA;
    localparam logic [3:0] RegBr  = 4'hB;
    localparam logic [3:0] RegSr  = 4'hC;
    localparam logic [3:0] RegTx  = 4'hD;
    localparam logic [3:0] RegRx  = 4'hE;
    localparam logic [3:0] RegCs  = 4'hF;

    state_e     state_q, state_d;
    logic       cs_q, cs_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       init_done_q, init_done_d;

    logic       op_en;
    logic       op_we;
    logic [3:0] op_reg;
    logic [7:0] op_din;
    logic       op_done;
    logic       accept;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    logic        poll_expire;

    // The read completing now is the POLL_MAX-th status read of this wait
    assign poll_expire = (poll_cnt_q + 16'd1) >= POLL_MAX;
`endif

    assign op_done  = cs_q & bus_rdy;
    // cs_q is always low in IDLE/NEXT except while a previous op is still being retired
    assign tx_ready = ((state_q == StIdle) || (state_q == StNext)) && !cs_q;
    assign accept   = tx_valid & tx_ready;

    // Bus operation owned by each state
    always_comb begin
        op_en  = 1'b1;
        op_we  = 1'b0;
        op_reg = 4'h0;
        op_din = 8'h00;
        unique case (state_q)
            StCfgBr:    begin op_we = 1'b1; op_reg = RegBr;  op_din = BR_VAL;  end
            StCfgCr2:   begin op_we = 1'b1; op_reg = RegCr2; op_din = CR2_VAL; end
            StCfgCr1:   begin op_we = 1'b1; op_reg = RegCr1; op_din = CR1_VAL; end
            StCsOn:     begin op_we = 1'b1; op_reg = RegCs;  op_din = 8'hFE;   end
            StPollTrdy: op_reg = RegSr;
            StWrTx:     begin op_we = 1'b1; op_reg = RegTx;  op_din = byte_q;  end
            StPollRrdy: op_reg = RegSr;
            StRdRx:     op_reg = RegRx;
            StCsOff:    begin op_we = 1'b1; op_reg = RegCs;  op_din = 8'hFF;   end
            default:    op_en = 1'b0;
        endcase
    end

    // Next-state, bus handshake and datapath updates
    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        byte_d      = byte_q;
        last_d      = last_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        init_done_d = init_done_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
        drop_d      = drop_q;
`endif

        // Launch when idle; retire on rdy. cs is low for one cycle between back-to-back ops.
        if (op_en && !cs_q) begin
            cs_d   = 1'b1;
            we_d   = op_we;
            addr_d = {BASE, op_reg};
            din_d  = op_din;
        end else if (op_done) begin
            cs_d   = 1'b0;
            we_d   = 1'b0;
            addr_d = 8'h00;
            din_d  = 8'h00;
        end

        unique case (state_q)
            StCfgBr:  if (op_done) state_d = StCfgCr2;
            StCfgCr2: if (op_done) state_d = StCfgCr1;
            StCfgCr1: begin
                if (op_done) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (accept) begin
`ifdef SPI_SEQ_TIMEOUT_EN
                    // Rest of a timed-out frame is swallowed up to its last byte
                    if (drop_q) begin
                        if (tx_last) drop_d = 1'b0;
                    end else
`endif
                    begin
                        byte_d  = tx_data;
                        last_d  = tx_last;
                        state_d = StCsOn;
                    end
                end
            end
            StCsOn: if (op_done) state_d = StPollTrdy;
            StPollTrdy: begin
                if (op_done) begin
                    if (bus_dout[4]) begin
                        state_d = StWrTx;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (poll_expire) begin
                        err_d   = 1'b1;
                        drop_d  = !last_q;
                        state_d = StCsOff;
                    end
`endif
                end
            end
            StWrTx: if (op_done) state_d = StPollRrdy;
            StPollRrdy: begin
                if (op_done) begin
                    if (bus_dout[3]) begin
                        state_d = StRdRx;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (poll_expire) begin
                        err_d   = 1'b1;
                        drop_d  = !last_q;
                        state_d = StCsOff;
                    end
`endif
                end
            end
            StRdRx: begin
                if (op_done) begin
                    rx_data_d  = bus_dout;
                    rx_valid_d = 1'b1;
                    state_d    = last_q ? StCsOff : StNext;
                end
            end
            StNext: begin
                if (accept) begin
                    byte_d  = tx_data;
                    last_d  = tx_last;
                    state_d = StPollTrdy;
                end
            end
            StCsOff: if (op_done) state_d = StIdle;
            default: state_d = StCfgBr;
        endcase

`ifdef SPI_SEQ_TIMEOUT_EN
        if (op_done && ((state_q == StPollTrdy) || (state_q == StPollRrdy))) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
        end
        if ((state_d != state_q) && ((state_d == StPollTrdy) || (state_d == StPollRrdy))) begin
            poll_cnt_d = 16'd0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StCfgBr;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            din_q       <= 8'h00;
            byte_q      <= 8'h00;
            last_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // Poll counter, sticky error and frame-drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt_q <= 16'd0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign bus_cs    = cs_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_din   = din_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != StCfgBr) && (state_q != StCfgCr2) &&
                       (state_q != StCfgCr1) && (state_q != StIdle);

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: directed bench for spi_xfer_seq with a wishbone-wrapper model that answers
// one cycle after cs, loops TXDR back to RXDR and can stall TRDY or withhold RRDY.
`timescale 1ns / 1ps

module tb_spi_xfer_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bus_cs, bus_we;
    logic [7:0] bus_addr, bus_din;
    logic [7:0] bus_dout;
    logic       bus_rdy;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready, rx_valid, init_done, busy, err_timeout;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

`ifdef SPI_SEQ_TIMEOUT_EN
    spi_xfer_seq #(.POLL_MAX(16'd4)) u_dut (
`else
    spi_xfer_seq u_dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .bus_cs     (bus_cs),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_din    (bus_din),
        .bus_dout   (bus_dout),
        .bus_rdy    (bus_rdy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .init_done  (init_done),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    // Wrapper model state
    int         stall = 0;
    bit         rrdy_never = 1'b0;
    int         trdy_cnt;
    logic [7:0] loop_q;
    logic       trdy, rrdy;
    int         cyc = 0;

    assign trdy     = (trdy_cnt >= stall);
    assign rrdy     = !rrdy_never;
    assign bus_dout = (bus_addr == 8'h0C) ? {3'b000, trdy, rrdy, 3'b000} :
                      (bus_addr == 8'h0E) ? loop_q : 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Host-port responder: rdy one cycle after cs
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdy  <= 1'b0;
            trdy_cnt <= 0;
            loop_q   <= 8'h00;
        end else begin
            bus_rdy <= bus_cs && !bus_rdy;
            if (bus_cs && bus_rdy && bus_we && (bus_addr == 8'h0F)) trdy_cnt <= 0;
            if (bus_cs && bus_rdy && bus_we && (bus_addr == 8'h0D)) begin
                loop_q   <= bus_din;
                trdy_cnt <= 0;
            end
            if (bus_cs && bus_rdy && !bus_we && (bus_addr == 8'h0C)) trdy_cnt <= trdy_cnt + 1;
        end
    end

    // Observation logs, sampled on the falling edge
    logic [16:0] oplog[$];
    logic [7:0]  rxq[$];
    int          rxcyc[$];
    int          bad_ready = 0;
    int          ready_cnt = 0;

    always @(negedge clk) begin
        if (bus_cs && bus_rdy) oplog.push_back({bus_we, bus_addr, bus_we ? bus_din : bus_dout});
        if (rx_valid) begin
            rxq.push_back(rx_data);
            rxcyc.push_back(cyc);
        end
        if (tx_ready && (!init_done || bus_cs)) bad_ready <= bad_ready + 1;
        if (tx_ready) ready_cnt <= ready_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic clear_logs();
        oplog.delete();
        rxq.delete();
        rxcyc.delete();
    endtask

    // Present one byte and hold it until accepted; returns the accept cycle number
    task automatic send_byte(input logic [7:0] d, input logic l, output int acc);
        int k;
        k = 0;
        acc = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL send_%h: tx_ready got 0 after 400 cycles, required 1", d);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
        end
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    // Wait for the sequencer to settle back in IDLE
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!(tx_ready && !busy) && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 600) begin
            n_err++;
            $display("FAIL %s_idle: busy=%0b tx_ready=%0b, required 0/1", tag, busy, tx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_cs, bus_we, bus_addr, bus_din, tx_ready, rx_valid, rx_data, init_done, busy,
             err_timeout} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_outputs: cs=%0b we=%0b addr=%h din=%h rdy=%0b rxv=%0b rx=%h",
                     bus_cs, bus_we, bus_addr, bus_din, tx_ready, rx_valid, rx_data);
        end
    endtask

    task automatic test_config();
        logic [16:0] exp[3];
        int k;
        exp[0] = {1'b1, 8'h0B, 8'h05};
        exp[1] = {1'b1, 8'h0A, 8'hC0};
        exp[2] = {1'b1, 8'h09, 8'h80};
        clear_logs();
        rst = 1'b1;
        k = 0;
        while (!init_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_init_done: got %0b, required 1", init_done);
        end
        @(negedge clk);
        n_cmp++;
        if (oplog.size() != 3) begin
            n_err++;
            $display("FAIL cfg_op_count: got %0d, required 3", oplog.size());
        end
        for (int i = 0; i < 3 && i < oplog.size(); i++) begin
            n_cmp++;
            if (oplog[i] !== exp[i]) begin
                n_err++;
                $display("FAIL cfg_op%0d: got %h, required %h", i, oplog[i], exp[i]);
            end
        end
        n_cmp++;
        if (tx_ready !== 1'b1 || bad_ready != 0) begin
            n_err++;
            $display("FAIL cfg_tx_ready: got %0b (early %0d), required 1 (0)", tx_ready,
                     bad_ready);
        end
    endtask

    task automatic test_single();
        logic [16:0] exp[6];
        int acc;
        exp[0] = {1'b1, 8'h0F, 8'hFE};
        exp[1] = {1'b0, 8'h0C, 8'h18};
        exp[2] = {1'b1, 8'h0D, 8'hA5};
        exp[3] = {1'b0, 8'h0C, 8'h18};
        exp[4] = {1'b0, 8'h0E, 8'hA5};
        exp[5] = {1'b1, 8'h0F, 8'hFF};
        clear_logs();
        send_byte(8'hA5, 1'b1, acc);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy: got %0b, required 1", busy);
        end
        wait_idle("single");
        n_cmp++;
        if (oplog.size() != 6) begin
            n_err++;
            $display("FAIL single_op_count: got %0d, required 6", oplog.size());
        end
        for (int i = 0; i < 6 && i < oplog.size(); i++) begin
            n_cmp++;
            if (oplog[i] !== exp[i]) begin
                n_err++;
                $display("FAIL single_op%0d: got %h, required %h", i, oplog[i], exp[i]);
            end
        end
        n_cmp++;
        if (rxq.size() != 1 || rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_rx: got %0d pulses data %h, required 1 pulse a5",
                     rxq.size(), rx_data);
        end
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL single_err: got %0b, required 0", err_timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rx[3];
        int acc[3];
        int n_fe, n_ff;
        exp_rx[0] = 8'h11;
        exp_rx[1] = 8'h22;
        exp_rx[2] = 8'h33;
        clear_logs();
        for (int i = 0; i < 3; i++) send_byte(exp_rx[i], (i == 2), acc[i]);
        wait_idle("frame");
        n_fe = 0;
        n_ff = 0;
        foreach (oplog[i]) begin
            if (oplog[i] == {1'b1, 8'h0F, 8'hFE}) n_fe++;
            if (oplog[i] == {1'b1, 8'h0F, 8'hFF}) n_ff++;
        end
        n_cmp++;
        if (n_fe != 1 || n_ff != 1 || oplog.size() != 14) begin
            n_err++;
            $display("FAIL frame_cs_ops: got FE=%0d FF=%0d ops=%0d, required 1 1 14",
                     n_fe, n_ff, oplog.size());
        end
        n_cmp++;
        if (rxq.size() != 3) begin
            n_err++;
            $display("FAIL frame_rx_count: got %0d, required 3", rxq.size());
        end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            n_cmp++;
            if (rxq[i] !== exp_rx[i]) begin
                n_err++;
                $display("FAIL frame_rx%0d: got %h, required %h", i, rxq[i], exp_rx[i]);
            end
        end
        if (rxcyc.size() == 3) begin
            n_cmp++;
            if (rxcyc[1] - acc[1] > 12 || rxcyc[1] - acc[1] < 1) begin
                n_err++;
                $display("FAIL frame_latency: got %0d clk, required 1..12",
                         rxcyc[1] - acc[1]);
            end
        end
    endtask

    task automatic test_trdy_stall();
        int acc, n_c, k, r0;
        clear_logs();
        stall = 5;
        r0 = 0;
        send_byte(8'h3C, 1'b1, acc);
        r0 = ready_cnt;
        k = 0;
        while (rxq.size() == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (ready_cnt != r0) begin
            n_err++;
            $display("FAIL stall_tx_ready: got %0d ready cycles, required 0", ready_cnt - r0);
        end
        wait_idle("stall");
        stall = 0;
        n_c = 0;
        foreach (oplog[i]) begin
            if (oplog[i][16:8] == {1'b1, 8'h0D}) break;
            if (oplog[i][16:8] == {1'b0, 8'h0C}) n_c++;
        end
        n_cmp++;
        if (n_c != 6) begin
            n_err++;
            $display("FAIL stall_polls: got %0d reads of C before D, required 6", n_c);
        end
        n_cmp++;
        if (rx_data !== 8'h3C) begin
            n_err++;
            $display("FAIL stall_rx: got %h, required 3c", rx_data);
        end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [16:0] exp[8];
        int acc, nlog;
        exp[0] = {1'b1, 8'h0F, 8'hFE};
        exp[1] = {1'b0, 8'h0C, 8'h10};
        exp[2] = {1'b1, 8'h0D, 8'h5A};
        for (int i = 3; i < 7; i++) exp[i] = {1'b0, 8'h0C, 8'h10};
        exp[7] = {1'b1, 8'h0F, 8'hFF};
        clear_logs();
        rrdy_never = 1'b1;
        send_byte(8'h5A, 1'b0, acc);
        wait_idle("timeout");
        n_cmp++;
        if (err_timeout !== 1'b1 || rxq.size() != 0) begin
            n_err++;
            $display("FAIL timeout_err: got err=%0b rx=%0d, required 1 0", err_timeout,
                     rxq.size());
        end
        n_cmp++;
        if (oplog.size() != 8) begin
            n_err++;
            $display("FAIL timeout_op_count: got %0d, required 8", oplog.size());
        end
        for (int i = 0; i < 8 && i < oplog.size(); i++) begin
            n_cmp++;
            if (oplog[i] !== exp[i]) begin
                n_err++;
                $display("FAIL timeout_op%0d: got %h, required %h", i, oplog[i], exp[i]);
            end
        end
        // The rest of the frame is taken and dropped without bus traffic
        nlog = oplog.size();
        send_byte(8'h6B, 1'b1, acc);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (oplog.size() != nlog || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_drop: got %0d new ops busy=%0b, required 0 0",
                     oplog.size() - nlog, busy);
        end
        rrdy_never = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int acc, k, nrx;
        bit seen_d;
        logic [16:0] exp[3];
        exp[0] = {1'b1, 8'h0B, 8'h05};
        exp[1] = {1'b1, 8'h0A, 8'hC0};
        exp[2] = {1'b1, 8'h09, 8'h80};
        clear_logs();
        rrdy_never = 1'b1;
        send_byte(8'h77, 1'b1, acc);
        seen_d = 1'b0;
        k = 0;
        while (!seen_d && k < 100) begin
            foreach (oplog[i]) if (oplog[i][16:8] == {1'b1, 8'h0D}) seen_d = 1'b1;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!seen_d) begin
            n_err++;
            $display("FAIL rstmid_reach: got no TXDR write, required one");
        end
        repeat (3) @(negedge clk);
        nrx = rxq.size();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus_cs, bus_we, bus_addr, bus_din, tx_ready, rx_valid, rx_data, init_done, busy,
             err_timeout} !== 33'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs: cs=%0b addr=%h rdy=%0b rx=%h init=%0b busy=%0b",
                     bus_cs, bus_addr, tx_ready, rx_data, init_done, busy);
        end
        rrdy_never = 1'b0;
        @(negedge clk);
        clear_logs();
        rst = 1'b1;
        k = 0;
        while (!init_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_cmp++;
        if (oplog.size() != 3 || nrx != 0) begin
            n_err++;
            $display("FAIL rstmid_recfg: got %0d ops rx=%0d, required 3 0", oplog.size(), nrx);
        end
        for (int i = 0; i < 3 && i < oplog.size(); i++) begin
            n_cmp++;
            if (oplog[i] !== exp[i]) begin
                n_err++;
                $display("FAIL rstmid_op%0d: got %h, required %h", i, oplog[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_single();
        test_back_to_back();
        test_trdy_stall();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
